// File: rtl/multi_row_fetcher_if.sv
// Job-control, Avalon-MM read and per-row FIFO write signals of multi_row_fetcher.
// master = the fetcher, slave = memory/FIFO/controller side.
interface multi_row_fetcher_if #(
    parameter int NUM_ROWS       = 9,
    parameter int BYTES_PER_WORD = 8,
    parameter int SEL_W          = 4
);
    localparam int DATA_W = 8 * BYTES_PER_WORD;
    localparam int BIDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    logic                start;
    logic [31:0]         base_addr;
    logic [31:0]         mem_address;
    logic                mem_read;
    logic [DATA_W-1:0]   mem_readdata;
    logic                mem_readdatavalid;
    logic                mem_waitrequest;
    logic [NUM_ROWS-1:0] fifo_full;
    logic [7:0]          fifo_data;
    logic [SEL_W-1:0]    fifo_sel;
    logic [BIDX_W-1:0]   fifo_byte_idx;
    logic                fifo_wren;
    logic                busy;
    logic                done;

    modport master (
        input  start, base_addr, mem_readdata, mem_readdatavalid, mem_waitrequest, fifo_full,
        output mem_address, mem_read, fifo_data, fifo_sel, fifo_byte_idx, fifo_wren, busy, done
    );

    modport slave (
        output start, base_addr, mem_readdata, mem_readdatavalid, mem_waitrequest, fifo_full,
        input  mem_address, mem_read, fifo_data, fifo_sel, fifo_byte_idx, fifo_wren, busy, done
    );
endinterface

// File: rtl/multi_row_fetcher.sv
// Fetches NUM_ROWS words from base_addr over Avalon-MM and unpacks them byte-wise into per-row FIFOs.
// Optional macro FETCH_PREFETCH_EN adds a second word buffer so the next row is read during unpack.
module multi_row_fetcher #(
    parameter int NUM_ROWS       = 9,
    parameter int BYTES_PER_WORD = 8,
    parameter int SEL_W          = 4
) (
    input  logic                clk,
    input  logic                rst,
    multi_row_fetcher_if.master bus
);
    localparam int DATA_W = 8 * BYTES_PER_WORD;
    localparam int BIDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int FULL_W = 1 << SEL_W;
    localparam logic [SEL_W-1:0]  LAST_ROW  = SEL_W'(NUM_ROWS - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {IDLE, READ_REQ, WAIT_DATA, UNPACK, FETCH_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [31:0]         r_base;
    logic [SEL_W-1:0]    r_row;
    logic [BIDX_W-1:0]   r_byte;
    logic [DATA_W-1:0]   r_buf;
    logic [FULL_W-1:0]   w_full_vec;
    logic [31:0]         w_row32;
    logic [7:0]          w_byte;
    logic                w_row_last, w_byte_last, w_emit, w_finish;
`ifdef FETCH_PREFETCH_EN
    logic [DATA_W-1:0]   r_nbuf;
    logic                r_nvld, r_pf_out;
    logic                w_pf_req, w_pf_hit;
`endif

    // Full flags padded to the select range so any row index is a legal lookup.
    always_comb begin
        w_full_vec                = '0;
        w_full_vec[NUM_ROWS-1:0]  = bus.fifo_full;
    end

    assign w_row32     = {{(32-SEL_W){1'b0}}, r_row};
    assign w_byte      = r_buf[{r_byte, 3'b000} +: 8];
    assign w_row_last  = (r_row == LAST_ROW);
    assign w_byte_last = (r_byte == LAST_BYTE);
    assign w_emit      = (r_state == UNPACK) && !w_full_vec[r_row];
    assign w_finish    = w_emit && w_byte_last;

`ifdef FETCH_PREFETCH_EN
    // Next row is requested only when nothing is in flight or parked, capping it at two words.
    assign w_pf_req = (r_state == UNPACK) && !w_row_last && !r_pf_out && !r_nvld;
    assign w_pf_hit = r_pf_out && bus.mem_readdatavalid;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt       = r_state;
        bus.mem_read      = 1'b0;
        bus.mem_address   = '0;
        bus.fifo_wren     = w_emit;
        bus.fifo_data     = '0;
        bus.fifo_sel      = '0;
        bus.fifo_byte_idx = '0;
        bus.busy          = 1'b0;
        bus.done          = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_state_nxt = READ_REQ;
            end
            READ_REQ: begin
                bus.busy        = 1'b1;
                bus.mem_read    = 1'b1;
                bus.mem_address = r_base + w_row32;
                if (!bus.mem_waitrequest) w_state_nxt = WAIT_DATA;
            end
            WAIT_DATA: begin
                bus.busy = 1'b1;
                if (bus.mem_readdatavalid) w_state_nxt = UNPACK;
            end
            UNPACK: begin
                bus.busy          = 1'b1;
                bus.fifo_data     = w_byte;
                bus.fifo_sel      = r_row;
                bus.fifo_byte_idx = r_byte;
`ifdef FETCH_PREFETCH_EN
                if (w_pf_req) begin
                    bus.mem_read    = 1'b1;
                    bus.mem_address = r_base + w_row32 + 32'd1;
                end
`endif
                if (w_finish) begin
                    if (w_row_last)
                        w_state_nxt = FETCH_DONE;
`ifdef FETCH_PREFETCH_EN
                    else if (r_nvld || w_pf_hit)
                        w_state_nxt = UNPACK;
                    else if (r_pf_out || (w_pf_req && !bus.mem_waitrequest))
                        w_state_nxt = WAIT_DATA;
`endif
                    else
                        w_state_nxt = READ_REQ;
                end
            end
            FETCH_DONE: begin
                bus.done    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
            r_row  <= '0;
            r_byte <= '0;
            r_buf  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_base <= bus.base_addr;
                    r_row  <= '0;
                    r_byte <= '0;
                end
                WAIT_DATA: if (bus.mem_readdatavalid) begin
                    r_buf  <= bus.mem_readdata;
                    r_byte <= '0;
                end
                UNPACK: if (w_emit) begin
                    r_byte <= w_byte_last ? '0 : r_byte + 1'b1;
                    if (w_finish && !w_row_last) begin
                        r_row <= r_row + 1'b1;
`ifdef FETCH_PREFETCH_EN
                        if (r_nvld)        r_buf <= r_nbuf;
                        else if (w_pf_hit) r_buf <= bus.mem_readdata;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PREFETCH_EN
    // In-flight/parked prefetch is handed to WAIT_DATA or r_buf at row end, so it always clears there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nbuf   <= '0;
            r_nvld   <= 1'b0;
            r_pf_out <= 1'b0;
        end else if (r_state != UNPACK || w_finish) begin
            r_nvld   <= 1'b0;
            r_pf_out <= 1'b0;
        end else if (w_pf_hit) begin
            r_nbuf   <= bus.mem_readdata;
            r_nvld   <= 1'b1;
            r_pf_out <= 1'b0;
        end else if (w_pf_req && !bus.mem_waitrequest) begin
            r_pf_out <= 1'b1;
        end
    end
`endif
endmodule
